// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch front end: reset defaults, PC step and
// the layout of one fetch-queue entry ({pc, instr}, instr in the low bits).
package fetch_unit_pkg;

  localparam int unsigned XLEN_DEFAULT     = 32;
  localparam int unsigned DEPTH_DEFAULT    = 4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int unsigned PC_STEP_DEFAULT  = 4;

  // Instruction word width; the PC field sits directly above it in an entry.
  localparam int unsigned INSTR_W = 32;

  // Width of a queue entry for a given PC width.
  function automatic int unsigned entry_width(input int unsigned xlen);
    return xlen + INSTR_W;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/grant bus with in-order responses. The master
// side is the fetch engine, the slave side is the instruction memory.
interface fetch_unit_if
  import fetch_unit_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT
);

  logic               imem_req_o;
  logic [XLEN-1:0]    imem_addr_o;
  logic               imem_gnt_i;
  logic               imem_rvalid_i;
  logic [INSTR_W-1:0] imem_rdata_i;

  modport master (
    output imem_req_o,
    output imem_addr_o,
    input  imem_gnt_i,
    input  imem_rvalid_i,
    input  imem_rdata_i
  );

  modport slave (
    input  imem_req_o,
    input  imem_addr_o,
    output imem_gnt_i,
    output imem_rvalid_i,
    output imem_rdata_i
  );

endinterface

// File: rtl/fetch_unit_sync_fifo.sv
// Synchronous FIFO with flush. Head data reads as zero while empty so that
// consumers never see X before the first write. DEPTH must be a power of 2.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       empty_o
);

  localparam int unsigned AddrW = $clog2(DEPTH);
  localparam int unsigned CntW  = $clog2(DEPTH+1);
  localparam logic [CntW-1:0] DepthC = CntW'(DEPTH);
  localparam logic [CntW-1:0] OneC   = CntW'(1);
  localparam logic [AddrW-1:0] OneA  = AddrW'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AddrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             full, do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full    = (count_q == DepthC);
  assign count_o = count_q;
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

  // Flush wins over push and pop; a push into a full FIFO needs a concurrent pop.
  assign do_pop  = pop_i && !empty_o && !flush_i;
  assign do_push = push_i && !flush_i && (!full || do_pop);

  // Next-state for pointers and occupancy.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + OneA;
      if (do_pop)  rd_ptr_d = rd_ptr_q + OneA;
      unique case ({do_push, do_pop})
        2'b10:   count_d = count_q + OneC;
        2'b01:   count_d = count_q - OneC;
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer/occupancy registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are only read once written, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/fetch_unit.sv
// Decoupled instruction-fetch engine. Requests are issued only while the
// queue can absorb every in-flight response (credit = count + outstanding),
// so a response never meets a full queue. A redirect flushes the queue and
// marks all still-outstanding responses for dropping.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned     XLEN     = XLEN_DEFAULT,
  parameter int unsigned     DEPTH    = DEPTH_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT),
  parameter int unsigned     PC_STEP  = PC_STEP_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       redirect_i,
  input  logic [XLEN-1:0]            redirect_pc_i,
  fetch_unit_if.master               imem,
  output logic                       if_valid_o,
  output logic [INSTR_W-1:0]         if_instr_o,
  output logic [XLEN-1:0]            if_pc_o,
  input  logic                       id_ready_i,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count_o
);

  localparam int unsigned      CntW   = $clog2(DEPTH+1);
  localparam int unsigned      EntryW = entry_width(XLEN);
  localparam logic [XLEN-1:0]  Step   = XLEN'(PC_STEP);
  localparam logic [CntW:0]    DepthW = (CntW+1)'(DEPTH);
  localparam logic [CntW-1:0]  OneC   = CntW'(1);

  logic [XLEN-1:0]   pc_q, pc_d, rpc_q, rpc_d;
  logic [CntW-1:0]   out_q, out_d, drop_q, drop_d;
  logic [CntW-1:0]   fifo_count;
  logic [CntW:0]     inflight;
  logic              credit, req, fire, rvalid, push, pop, fifo_empty;
  logic [EntryW-1:0] head;

  assign rvalid   = imem.imem_rvalid_i;
  assign inflight = {1'b0, fifo_count} + {1'b0, out_q};
  assign credit   = (inflight < DepthW);
  // Only registered state, redirect and reset feed the request.
  assign req      = !rst && !redirect_i && credit;
  assign fire     = req && imem.imem_gnt_i;
  assign push     = rvalid && (drop_q == '0) && !redirect_i;
  assign pop      = if_valid_o && id_ready_i && !redirect_i;

  assign imem.imem_req_o  = req;
  assign imem.imem_addr_o = pc_q;

  assign if_valid_o   = !fifo_empty;
  assign if_pc_o      = head[EntryW-1:INSTR_W];
  assign if_instr_o   = head[INSTR_W-1:0];
  assign fifo_count_o = fifo_count;

  // Next-state for fetch PC, response PC and the outstanding/drop counters.
  always_comb begin
    pc_d   = pc_q;
    rpc_d  = rpc_q;
    out_d  = out_q;
    drop_d = drop_q;
    if (fire) pc_d = pc_q + Step;
    if (fire && !rvalid) begin
      out_d = out_q + OneC;
    end else if (!fire && rvalid) begin
      out_d = out_q - OneC;
    end
    if (rvalid) begin
      if (drop_q != '0) drop_d = drop_q - OneC;
      else              rpc_d  = rpc_q + Step;
    end
    // No grant can happen here (req is low), so out_d = outstanding - rvalid.
    if (redirect_i) begin
      pc_d   = redirect_pc_i;
      rpc_d  = redirect_pc_i;
      drop_d = out_d;
    end
  end

  // Fetch state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q   <= RESET_PC;
      rpc_q  <= RESET_PC;
      out_q  <= '0;
      drop_q <= '0;
    end else begin
      pc_q   <= pc_d;
      rpc_q  <= rpc_d;
      out_q  <= out_d;
      drop_q <= drop_d;
    end
  end

  sync_fifo #(
    .WIDTH (EntryW),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .wdata_i ({rpc_q, imem.imem_rdata_i}),
    .pop_i   (pop),
    .flush_i (redirect_i),
    .rdata_o (head),
    .count_o (fifo_count),
    .empty_o (fifo_empty)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: an in-order memory model with programmable
// latency feeds responses; every granted address is pushed to an expected
// queue and compared, in order, against the entries decode pops.
module tb_fetch_unit;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        id_ready;
  logic [2:0]  fifo_count;

  fetch_unit_if #(.XLEN(32)) imem_if ();

  fetch_unit #(
    .XLEN     (32),
    .DEPTH    (DEPTH),
    .RESET_PC (32'h0),
    .PC_STEP  (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .imem          (imem_if.master),
    .if_valid_o    (if_valid),
    .if_instr_o    (if_instr),
    .if_pc_o       (if_pc),
    .id_ready_i    (id_ready),
    .fifo_count_o  (fifo_count)
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  int          cyc   = 0;
  int          lat   = 1;
  bit          gnt_rand = 1'b0;
  int          pops  = 0;
  bit          last_rvalid, last_valid;
  logic [31:0] pend_addr [$];
  int          pend_due  [$];
  logic [31:0] exp_q     [$];
  logic [31:0] got_pc    [$];
  logic [31:0] exp_fetch = 32'h0;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return (a * 32'd3) ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_addr"},  64'(imem_if.imem_addr_o), 64'(32'h0));
    check({tag, "_valid"}, 64'(if_valid),            64'(1'b0));
    check({tag, "_instr"}, 64'(if_instr),            64'(32'h0));
    check({tag, "_pc"},    64'(if_pc),               64'(32'h0));
    check({tag, "_count"}, 64'(fifo_count),          64'(3'd0));
  endtask

  // One clock cycle: drive memory response/grant, settle, score, advance.
  task automatic step();
    logic [31:0] e;
    if (pend_addr.size() != 0 && pend_due[0] <= cyc) begin
      imem_if.imem_rvalid_i = 1'b1;
      imem_if.imem_rdata_i  = instr_of(pend_addr[0]);
    end else begin
      imem_if.imem_rvalid_i = 1'b0;
      imem_if.imem_rdata_i  = $urandom;
    end
    imem_if.imem_gnt_i = gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    #1;
    last_rvalid = imem_if.imem_rvalid_i;
    last_valid  = if_valid;
    if (rst) begin
      check("req_in_reset", 64'(imem_if.imem_req_o), 64'(1'b0));
      pend_addr.delete();
      pend_due.delete();
      exp_q.delete();
      exp_fetch = 32'h0;
    end else begin
      check("count_bound", 64'(fifo_count <= 3'(DEPTH)), 64'(1'b1));
      if (redirect) check("req_on_redirect", 64'(imem_if.imem_req_o), 64'(1'b0));
      if (imem_if.imem_req_o && imem_if.imem_gnt_i) begin
        check("req_addr", 64'(imem_if.imem_addr_o), 64'(exp_fetch));
        pend_addr.push_back(imem_if.imem_addr_o);
        pend_due.push_back(cyc + lat);
        exp_q.push_back(exp_fetch);
        exp_fetch = exp_fetch + 32'd4;
      end
      if (imem_if.imem_rvalid_i) begin
        void'(pend_addr.pop_front());
        void'(pend_due.pop_front());
      end
      if (if_valid && id_ready && !redirect) begin
        if (exp_q.size() == 0) begin
          check("head_unexpected", 64'(if_valid), 64'(1'b0));
        end else begin
          e = exp_q.pop_front();
          check("head_pc",    64'(if_pc),    64'(e));
          check("head_instr", 64'(if_instr), 64'(instr_of(e)));
          got_pc.push_back(if_pc);
          pops++;
        end
      end
      if (redirect) begin
        exp_q.delete();
        exp_fetch = redirect_pc;
      end
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  initial begin
    rst         = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    id_ready    = 1'b1;
    imem_if.imem_gnt_i    = 1'b1;
    imem_if.imem_rvalid_i = 1'b0;
    imem_if.imem_rdata_i  = 32'h0;

    // Reset, then sustained streaming with latency-1 memory.
    step();
    step();
    check_reset_outs("reset");
    rst = 1'b0;
    pops = 0;
    got_pc.delete();
    repeat (20) step();
    check("stream_pops", 64'(pops), 64'(18));
    check("stream_first_pc", 64'(got_pc[0]), 64'(32'h0));

    // Mid-stream reset, then decode stalled: queue fills to DEPTH.
    rst = 1'b1;
    step();
    check_reset_outs("reset_mid");
    rst = 1'b0;
    id_ready = 1'b0;
    repeat (10) step();
    check("stall_count", 64'(fifo_count), 64'(3'd4));
    check("stall_req",   64'(imem_if.imem_req_o), 64'(1'b0));
    check("stall_addr",  64'(imem_if.imem_addr_o), 64'(32'h10));
    check("stall_head",  64'(if_pc), 64'(32'h0));
    id_ready = 1'b1;
    got_pc.delete();
    repeat (12) step();
    check("drain_pc3", 64'(got_pc[3]), 64'(32'hC));
    check("drain_pc4", 64'(got_pc[4]), 64'(32'h10));

    // Latency 3: three requests in flight, then redirect to 0x100.
    rst = 1'b1;
    step();
    rst = 1'b0;
    lat = 3;
    repeat (3) step();
    check("lat3_inflight", 64'(pend_addr.size()), 64'(3));
    redirect = 1'b1;
    redirect_pc = 32'h100;
    step();
    redirect = 1'b0;
    check("lat3_flush_count", 64'(fifo_count), 64'(3'd0));
    got_pc.delete();
    repeat (20) step();
    check("lat3_first_pc",  64'(got_pc[0]), 64'(32'h100));
    check("lat3_second_pc", 64'(got_pc[1]), 64'(32'h104));

    // Random grants with latency 2, then back to steady latency 1.
    lat = 2;
    gnt_rand = 1'b1;
    repeat (30) step();
    gnt_rand = 1'b0;
    lat = 1;
    repeat (8) step();

    // Redirect coincident with a response and a pop.
    redirect = 1'b1;
    redirect_pc = 32'h200;
    step();
    redirect = 1'b0;
    check("coinc_setup", 64'({last_rvalid, last_valid}), 64'(2'b11));
    check("coinc_count", 64'(fifo_count), 64'(3'd0));
    check("coinc_valid", 64'(if_valid), 64'(1'b0));
    got_pc.delete();
    repeat (10) step();
    check("coinc_first_pc", 64'(got_pc[0]), 64'(32'h200));

    // PC wrap at the top of the address space.
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect = 1'b0;
    got_pc.delete();
    repeat (8) step();
    check("wrap_pc0", 64'(got_pc[0]), 64'(32'hFFFF_FFFC));
    check("wrap_pc1", 64'(got_pc[1]), 64'(32'h0));
    check("wrap_pc2", 64'(got_pc[2]), 64'(32'h4));

    // Reset while streaming: outputs clear, fetch restarts at RESET_PC.
    rst = 1'b1;
    step();
    check_reset_outs("reset_stream");
    rst = 1'b0;
    got_pc.delete();
    repeat (8) step();
    check("restart_pc", 64'(got_pc[0]), 64'(32'h0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
